// File: rtl/shot_renderer.sv
// Sweeps the shot table once per frame tick, plotting each valid on-screen shot
// as a SHOT_SIZE square and requesting deletion of shots that have left the screen.
module shot_renderer #(
  parameter int unsigned SHOT_COUNT  = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned SCREEN_W    = 320,
  parameter int unsigned SCREEN_H    = 240,
  parameter int unsigned SHOT_SIZE   = 2,
  parameter logic [2:0]  SHOT_COLOUR = 3'b111
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              erase,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [24:0]       rd_data,
  output logic [8:0]        vga_x,
  output logic [8:0]        vga_y,
  output logic [2:0]        colour,
  output logic              plot,
  output logic              delete_shot,
  output logic [ADDR_W-1:0] shot_address,
  output logic              busy,
  output logic              done
);

  localparam int unsigned COORD_W = 9;
  localparam int unsigned CNT_W   = (SHOT_SIZE > 1) ? $clog2(SHOT_SIZE) : 1;

  localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(SCREEN_W - SHOT_SIZE);
  localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(SCREEN_H - SHOT_SIZE);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SHOT_SIZE - 1);
  localparam logic [ADDR_W-1:0]  SLOT_LAST = ADDR_W'(SHOT_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    CHECK = 3'd3,
    DRAW  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic                mode_erase;
  logic                rec_valid;
  logic [COORD_W-1:0]  rec_x;
  logic [COORD_W-1:0]  rec_y;
  logic [CNT_W-1:0]    dx;
  logic [CNT_W-1:0]    dy;

  // Record fields straight from the table; direction is not used here.
  logic               lat_valid;
  logic [COORD_W-1:0] lat_x;
  logic [COORD_W-1:0] lat_y;
  logic               lat_on_screen;
  logic               rec_on_screen;
  logic               last_pixel;
  logic               slot_end;
  logic               unused_dir;

  assign lat_valid     = rd_data[24];
  assign lat_y         = rd_data[23:15];
  assign lat_x         = rd_data[14:6];
  assign unused_dir    = ^rd_data[5:0];
  assign lat_on_screen = (lat_x <= X_MAX) && (lat_y <= Y_MAX);
  assign rec_on_screen = (rec_x <= X_MAX) && (rec_y <= Y_MAX);
  assign last_pixel    = (dx == CNT_LAST) && (dy == CNT_LAST);
  assign slot_end      = ((state == CHECK) && !(rec_valid && rec_on_screen)) ||
                         ((state == DRAW) && last_pixel);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      mode_erase   <= 1'b0;
      rec_valid    <= 1'b0;
      rec_x        <= '0;
      rec_y        <= '0;
      dx           <= '0;
      dy           <= '0;
      rd_addr      <= '0;
      shot_address <= '0;
      vga_x        <= '0;
      vga_y        <= '0;
      colour       <= '0;
      plot         <= 1'b0;
      delete_shot  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      delete_shot <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx        <= '0;
            rd_addr    <= '0;
            mode_erase <= erase;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          rec_valid <= lat_valid;
          rec_x     <= lat_x;
          rec_y     <= lat_y;
          // Decided one edge early so the request is visible during CHECK.
          if (lat_valid && !lat_on_screen && !mode_erase) begin
            delete_shot  <= 1'b1;
            shot_address <= idx;
          end
          state <= CHECK;
        end
        CHECK: begin
          if (rec_valid && rec_on_screen) begin
            dx     <= '0;
            dy     <= '0;
            vga_x  <= rec_x;
            vga_y  <= rec_y;
            colour <= mode_erase ? 3'b000 : SHOT_COLOUR;
            plot   <= 1'b1;
            state  <= DRAW;
          end
        end
        DRAW: begin
          if (last_pixel) begin
            plot <= 1'b0;
          end else if (dx == CNT_LAST) begin
            dx    <= '0;
            dy    <= dy + CNT_W'(1);
            vga_x <= rec_x;
            vga_y <= vga_y + COORD_W'(1);
          end else begin
            dx    <= dx + CNT_W'(1);
            vga_x <= vga_x + COORD_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Step to the next slot or finish the sweep.
      if (slot_end) begin
        if (idx == SLOT_LAST) begin
          done  <= 1'b1;
          state <= DONE;
        end else begin
          idx     <= idx + ADDR_W'(1);
          rd_addr <= idx + ADDR_W'(1);
          state   <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_shot_renderer.sv
// Directed bench for shot_renderer: per-vector sweeps against a synchronous
// shot table model, plus start re-pulse and mid-draw reset sequences.
module tb_shot_renderer;

  localparam int unsigned SHOT_COUNT = 8;
  localparam int unsigned ADDR_W     = 3;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              erase;
  logic [ADDR_W-1:0] rd_addr;
  logic [24:0]       rd_data;
  logic [8:0]        vga_x;
  logic [8:0]        vga_y;
  logic [2:0]        colour;
  logic              plot;
  logic              delete_shot;
  logic [ADDR_W-1:0] shot_address;
  logic              busy;
  logic              done;

  shot_renderer dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .erase(erase),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .vga_x(vga_x),
    .vga_y(vga_y),
    .colour(colour),
    .plot(plot),
    .delete_shot(delete_shot),
    .shot_address(shot_address),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [24:0] shot_tab [SHOT_COUNT];
  always @(posedge clk) rd_data <= shot_tab[rd_addr];

  typedef struct {
    int         slot;
    logic [24:0] rec;
    logic       erase;
    int         nplots;
    int         first_n;
    logic [8:0] x0;
    logic [8:0] y0;
    logic [2:0] col;
    int         ndel;
    int         del_n;
    int         done_n;
  } vec_t;

  vec_t vecs[10];
  int tests;
  int fails;

  function automatic logic [24:0] mk(input logic v, input logic [8:0] y,
                                     input logic [8:0] x, input logic [5:0] d);
    return {v, y, x, d};
  endfunction

  function automatic logic [31:0] outs();
    return 32'({plot, delete_shot, done, busy, rd_addr, shot_address, vga_x, vga_y, colour});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < SHOT_COUNT; i++) shot_tab[i] = '0;
  endtask

  // Cycle n = interval after edge E0+n, where E0 samples start.
  task automatic run_vec(input int id, input vec_t v);
    int np;
    int nd;
    int ndn;
    int bad_busy;
    logic [8:0] ex;
    logic [8:0] ey;
    np = 0; nd = 0; ndn = 0; bad_busy = 0;
    clear_table();
    shot_tab[v.slot] = v.rec;
    erase = v.erase;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 70; n++) begin
      if (plot) begin
        if (np < v.nplots) begin
          ex = v.x0 + 9'(np % 2);
          ey = v.y0 + 9'(np / 2);
          check($sformatf("v%0d_pixel%0d", id, np),
                32'({8'(n), vga_x, vga_y, colour}),
                32'({8'(v.first_n + np), ex, ey, v.col}));
        end
        np++;
      end
      if (delete_shot) begin
        if (nd == 0)
          check($sformatf("v%0d_delete", id), 32'({8'(n), 8'(shot_address)}),
                32'({8'(v.del_n), 8'(v.slot)}));
        nd++;
      end
      if (done) begin
        if (ndn == 0) check($sformatf("v%0d_done_cycle", id), 32'(n), 32'(v.done_n));
        ndn++;
      end
      if (busy !== (n <= v.done_n)) bad_busy++;
      @(negedge clk);
    end
    check($sformatf("v%0d_plot_count", id), 32'(np), 32'(v.nplots));
    check($sformatf("v%0d_delete_count", id), 32'(nd), 32'(v.ndel));
    check($sformatf("v%0d_done_count", id), 32'(ndn), 32'd1);
    check($sformatf("v%0d_busy_window", id), 32'(bad_busy), 32'd0);
  endtask

  initial begin
    int ndn;
    int done_at;
    int activity;
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    start = 1'b0;
    erase = 1'b0;
    clear_table();
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    //           slot rec                         er  np 1st  x0      y0      col     nd dn done
    vecs[0] = '{0, 25'h0,                       1'b0, 0, 0,  9'd0,   9'd0,   3'b000, 0, 0,  24};
    vecs[1] = '{2, mk(1'b1, 9'd10, 9'd20, 6'd5), 1'b0, 4, 9,  9'd20,  9'd10,  3'b111, 0, 0,  28};
    vecs[2] = '{5, mk(1'b1, 9'd50, 9'd319, 6'd0), 1'b0, 0, 0, 9'd0,   9'd0,   3'b000, 1, 17, 24};
    vecs[3] = '{3, mk(1'b1, 9'd20, 9'h1FF, 6'd0), 1'b0, 0, 0, 9'd0,   9'd0,   3'b000, 1, 11, 24};
    vecs[4] = '{7, mk(1'b1, 9'd238, 9'd318, 6'd2), 1'b0, 4, 24, 9'd318, 9'd238, 3'b111, 0, 0, 28};
    vecs[5] = '{2, mk(1'b1, 9'd10, 9'd20, 6'd5), 1'b1, 4, 9,  9'd20,  9'd10,  3'b000, 0, 0,  28};
    vecs[6] = '{5, mk(1'b1, 9'd50, 9'd319, 6'd0), 1'b1, 0, 0, 9'd0,   9'd0,   3'b000, 0, 0,  24};
    vecs[7] = '{0, mk(1'b1, 9'd239, 9'd0, 6'd0), 1'b0, 0, 0,  9'd0,   9'd0,   3'b000, 1, 2,  24};
    vecs[8] = '{1, mk(1'b0, 9'd10, 9'd20, 6'd3), 1'b0, 0, 0,  9'd0,   9'd0,   3'b000, 0, 0,  24};
    vecs[9] = '{4, mk(1'b1, 9'h1FF, 9'd5, 6'd0), 1'b0, 0, 0,  9'd0,   9'd0,   3'b000, 1, 14, 24};

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Start re-pulsed while busy, including during the DONE cycle.
    clear_table();
    erase = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndn = 0;
    done_at = -1;
    for (int n = 0; n < 60; n++) begin
      if (done) begin
        if (ndn == 0) done_at = n;
        ndn++;
      end
      start = (n == 5 || n == 20 || n == 24) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("repulse_done_count", 32'(ndn), 32'd1);
    check("repulse_done_cycle", 32'(done_at), 32'd24);
    check("repulse_idle_after", 32'({busy, plot}), 32'd0);

    // Reset asserted mid-DRAW.
    clear_table();
    shot_tab[2] = mk(1'b1, 9'd10, 9'd20, 6'd5);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_plot", 32'(plot), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("async_reset_plot_busy", 32'({plot, busy}), 32'd0);
    check("async_reset_outputs", outs(), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    activity = 0;
    for (int n = 0; n < 40; n++) begin
      if (plot || delete_shot || done || busy) activity++;
      @(negedge clk);
    end
    check("post_reset_quiet", 32'(activity), 32'd0);
    run_vec(99, vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
